// File: rtl/rv_pkg.sv
// Shared RV32I encodings, ALU op and operand-select types for the decode/execute/memory slice.
package rv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SLT  = 3'd5,
    ALU_SLTU = 3'd6
  } alu_op_e;

  typedef enum logic [1:0] {SRCA_ZERO, SRCA_PC, SRCA_RS1} srca_e;
  typedef enum logic       {SRCB_IMM, SRCB_RS2} srcb_e;
  typedef enum logic [1:0] {IMM_I, IMM_S, IMM_U, IMM_J} imm_fmt_e;

  typedef struct packed {
    logic     legal;
    alu_op_e  op;
    srca_e    sa;
    srcb_e    sb;
    imm_fmt_e fmt;
    logic     wen;
    logic     ld;
    logic     st;
    logic     jmp;
    logic     jalr;
  } dec_t;

  // func3 -> ALU op for the register/immediate arithmetic groups
  function automatic alu_op_e f3_op(input logic [2:0] f3);
    case (f3)
      3'b010:  f3_op = ALU_SLT;
      3'b011:  f3_op = ALU_SLTU;
      3'b100:  f3_op = ALU_XOR;
      3'b110:  f3_op = ALU_OR;
      3'b111:  f3_op = ALU_AND;
      default: f3_op = ALU_ADD;
    endcase
  endfunction

  function automatic logic [31:0] alu(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_SUB:  alu = a - b;
      ALU_AND:  alu = a & b;
      ALU_OR:   alu = a | b;
      ALU_XOR:  alu = a ^ b;
      ALU_SLT:  alu = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: alu = {31'd0, a < b};
      default:  alu = a + b;
    endcase
  endfunction

endpackage

// File: rtl/rv_load_align.sv
// Picks and extends the byte/half/word addressed by a load; misaligned halves/words read as 0.
module rv_load_align
  import rv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  func3,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] shifted;

  assign shifted  = rdata >> {addr, 3'b000};
  assign byte_sel = shifted[7:0];
  assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

  assign misaligned = ((func3[1:0] == 2'b01) && addr[0]) ||
                      ((func3[1:0] == 2'b10) && (addr != 2'b00));

  always_comb begin
    load_data = 32'd0;
    if (!misaligned) begin
      case (func3)
        3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
        3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
        3'b010:  load_data = rdata;
        3'b100:  load_data = {24'd0, byte_sel};
        3'b101:  load_data = {16'd0, half_sel};
        default: load_data = 32'd0;
      endcase
    end
  end

endmodule

// File: rtl/rv_decode_exec_mem.sv
// Single-cycle RV32I decode, ALU and data-memory stage with a sticky misalignment flag.
module rv_decode_exec_mem
  import rv_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int AW        = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output logic        rf_wen,
  output logic [2:0]  func3,
  output logic [6:0]  opcode,
  output logic [31:0] aluout,
  output logic [31:0] load_data,
  output logic        is_jump,
  output logic        ebreak,
  output logic        illegal,
  output logic        mem_fault
);

  dec_t        dec;
  logic [6:0]  func7;
  logic [31:0] op_a, op_b, alu_res;
  logic [31:0] rdata, wdata;
  logic [3:0]  be;
  logic [AW-1:0] widx;
  logic        ld_mis, st_mis, st_en, fault;

  logic [31:0] mem [MEM_WORDS];

  assign opcode = inst[6:0];
  assign rd     = inst[11:7];
  assign func3  = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign func7  = inst[31:25];
  assign ebreak = (inst == INST_EBREAK);

  always_comb begin
    dec    = '0;
    dec.op = ALU_ADD;
    dec.sa = SRCA_RS1;
    dec.sb = SRCB_IMM;
    dec.fmt = IMM_I;
    case (opcode)
      OPC_LUI:   begin dec.legal = 1'b1; dec.wen = 1'b1; dec.sa = SRCA_ZERO; dec.fmt = IMM_U; end
      OPC_AUIPC: begin dec.legal = 1'b1; dec.wen = 1'b1; dec.sa = SRCA_PC;   dec.fmt = IMM_U; end
      OPC_JAL: begin
        dec.legal = 1'b1; dec.wen = 1'b1; dec.jmp = 1'b1;
        dec.sa = SRCA_PC; dec.fmt = IMM_J;
      end
      OPC_JALR: begin
        dec.legal = (func3 == 3'b000);
        dec.wen = 1'b1; dec.jmp = 1'b1; dec.jalr = 1'b1;
      end
      OPC_LOAD: begin
        dec.legal = (func3 != 3'b011) && (func3 != 3'b110) && (func3 != 3'b111);
        dec.wen = 1'b1; dec.ld = 1'b1;
      end
      OPC_STORE: begin
        dec.legal = (func3[2] == 1'b0) && (func3[1:0] != 2'b11);
        dec.st = 1'b1; dec.fmt = IMM_S;
      end
      OPC_OPIMM: begin
        // func3 001/101 are the shift-immediates, not part of this core
        dec.legal = (func3[1:0] != 2'b01);
        dec.wen = 1'b1; dec.op = f3_op(func3);
      end
      OPC_OP: begin
        dec.legal = ((func7 == 7'b0000000) && (func3[1:0] != 2'b01)) ||
                    ((func7 == 7'b0100000) && (func3 == 3'b000));
        dec.wen = 1'b1; dec.sb = SRCB_RS2;
        dec.op = inst[30] ? ALU_SUB : f3_op(func3);
      end
      OPC_SYSTEM: dec.legal = ebreak;
      default:    dec.legal = 1'b0;
    endcase
  end

  assign illegal = !dec.legal;
  assign is_jump = dec.jmp && dec.legal;
  assign rf_wen  = dec.wen && dec.legal && (rd != 5'd0);

  always_comb begin
    case (dec.fmt)
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_U:   imm = {inst[31:12], 12'd0};
      IMM_J:   imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = {{20{inst[31]}}, inst[31:20]};
    endcase
  end

  always_comb begin
    case (dec.sa)
      SRCA_ZERO: op_a = 32'd0;
      SRCA_PC:   op_a = pc;
      default:   op_a = src1;
    endcase
  end

  assign op_b    = (dec.sb == SRCB_RS2) ? src2 : imm;
  assign alu_res = alu(dec.op, op_a, op_b);
  assign aluout  = dec.jalr ? {alu_res[31:1], 1'b0} : alu_res;

  // Upper address bits are dropped, so accesses wrap modulo the array size
  assign widx  = aluout[AW+1:2];
  assign rdata = mem[widx];

  rv_load_align u_align (
    .rdata      (rdata),
    .addr       (aluout[1:0]),
    .func3      (func3),
    .load_data  (load_data),
    .misaligned (ld_mis)
  );

  assign st_mis = ((func3[1:0] == 2'b01) && aluout[0]) ||
                  ((func3[1:0] == 2'b10) && (aluout[1:0] != 2'b00));

  always_comb begin
    be    = 4'b0000;
    wdata = src2;
    case (func3[1:0])
      2'b00: begin be = 4'b0001 << aluout[1:0];         wdata = {4{src2[7:0]}};  end
      2'b01: begin be = aluout[1] ? 4'b1100 : 4'b0011;  wdata = {2{src2[15:0]}}; end
      2'b10: begin be = 4'b1111;                        wdata = src2;            end
      default: be = 4'b0000;
    endcase
  end

  assign st_en = dec.st && dec.legal && !st_mis && rst;
  assign fault = dec.legal && ((dec.ld && ld_mis) || (dec.st && st_mis));

  always_ff @(posedge clk) begin
    if (st_en) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)       mem_fault <= 1'b0;
    else if (fault) mem_fault <= 1'b1;
  end

endmodule

// File: tb/tb_rv_decode_exec_mem.sv
// Bench for rv_decode_exec_mem: decode/ALU vector table plus memory and fault sequences.
module tb_rv_decode_exec_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst, pc, src1, src2;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm, aluout, load_data;
  logic        rf_wen, is_jump, ebreak, illegal, mem_fault;
  logic [2:0]  func3;
  logic [6:0]  opcode;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rv_decode_exec_mem #(.MEM_WORDS(1024), .AW(10)) dut (
    .clk(clk), .rst(rst), .inst(inst), .pc(pc), .src1(src1), .src2(src2),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .rf_wen(rf_wen), .func3(func3),
    .opcode(opcode), .aluout(aluout), .load_data(load_data), .is_jump(is_jump),
    .ebreak(ebreak), .illegal(illegal), .mem_fault(mem_fault)
  );

  typedef struct {
    logic [31:0] inst, pc, s1, s2;
    logic [31:0] imm, alu;
    logic        ci, ca;
    logic [4:0]  rd;
    logic        wen, ill, jmp, brk;
  } vec_t;

  typedef struct {
    string       nm;
    logic [31:0] exp;
    int          sel;
  } exp_t;

  vec_t vecs[14];
  vec_t q_vec[$];
  exp_t q_exp[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] i, p, a, b, im, al, input logic ci, ca,
                              input logic [4:0] r, input logic w, il, j, e);
    vec_t v;
    v.inst = i; v.pc = p; v.s1 = a; v.s2 = b; v.imm = im; v.alu = al;
    v.ci = ci; v.ca = ca; v.rd = r; v.wen = w; v.ill = il; v.jmp = j; v.brk = e;
    return v;
  endfunction

  task automatic drive(input logic [31:0] i, a, b);
    @(negedge clk);
    inst = i; pc = 32'h0; src1 = a; src2 = b;
  endtask

  // queue an expected value on one output (sel: 0 load_data, 1 mem_fault) and compare after settling
  task automatic expect_now(input string nm, input int sel, input logic [31:0] e);
    exp_t x, y;
    logic [31:0] act;
    x.nm = nm; x.exp = e; x.sel = sel;
    q_exp.push_back(x);
    #1;
    y = q_exp.pop_front();
    act = (y.sel == 0) ? load_data : {31'd0, mem_fault};
    chk(y.nm, act, y.exp);
  endtask

  localparam logic [31:0] SW_I  = 32'h0020A023, SH_I  = 32'h00209023, SB_I = 32'h00208023;
  localparam logic [31:0] LW_I  = 32'h0000A083, LB_I  = 32'h00008083, LH_I = 32'h00009083;
  localparam logic [31:0] LHU_I = 32'h0000D083, NOP_I = 32'h00000013;

  initial begin
    vec_t v, e;
    vecs[0]  = mk(32'hFFB00093, 0, 0, 0, 32'hFFFFFFFB, 32'hFFFFFFFB, 1, 1, 1, 1, 0, 0, 0);
    vecs[1]  = mk(32'h12345117, 32'h80000000, 0, 0, 32'h12345000, 32'h92345000, 1, 1, 2, 1, 0, 0, 0);
    vecs[2]  = mk(32'h004280E7, 0, 32'h1003, 0, 32'h4, 32'h1006, 1, 1, 1, 1, 0, 1, 0);
    vecs[3]  = mk(32'h00100073, 0, 0, 0, 32'h1, 0, 1, 0, 0, 0, 0, 0, 1);
    vecs[4]  = mk(32'h00109093, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    vecs[5]  = mk(32'h402081B3, 0, 5, 7, 0, 32'hFFFFFFFE, 0, 1, 3, 1, 0, 0, 0);
    vecs[6]  = mk(32'h0020A233, 0, 32'hFFFFFFFF, 1, 0, 1, 0, 1, 4, 1, 0, 0, 0);
    vecs[7]  = mk(32'h0020B233, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 1, 4, 1, 0, 0, 0);
    vecs[8]  = mk(32'h0F037293, 0, 32'h12345678, 0, 32'hF0, 32'h70, 1, 1, 5, 1, 0, 0, 0);
    vecs[9]  = mk(32'hFFFFF3B7, 0, 32'hAAAA, 0, 32'hFFFFF000, 32'hFFFFF000, 1, 1, 7, 1, 0, 0, 0);
    vecs[10] = mk(32'hFF9FF0EF, 32'h100, 0, 0, 32'hFFFFFFF8, 32'hF8, 1, 1, 1, 1, 0, 1, 0);
    vecs[11] = mk(32'h00000063, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    vecs[12] = mk(32'h00100013, 0, 0, 0, 32'h1, 32'h1, 1, 1, 0, 0, 0, 0, 0);
    vecs[13] = mk(32'h003160B3, 0, 32'hF0F0, 32'h0F0F, 0, 32'hFFFF, 0, 1, 1, 1, 0, 0, 0);

    rst = 1'b0; inst = NOP_I; pc = 0; src1 = 0; src2 = 0;
    repeat (2) @(negedge clk);
    expect_now("reset_mem_fault", 1, 0);
    rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      v = vecs[i];
      @(negedge clk);
      inst = v.inst; pc = v.pc; src1 = v.s1; src2 = v.s2;
      q_vec.push_back(v);
      #1;
      e = q_vec.pop_front();
      if (e.ci) chk($sformatf("v%0d_imm", i), imm, e.imm);
      if (e.ca) chk($sformatf("v%0d_aluout", i), aluout, e.alu);
      chk($sformatf("v%0d_rd", i), {27'd0, rd}, {27'd0, e.rd});
      chk($sformatf("v%0d_ctl", i), {28'd0, rf_wen, illegal, is_jump, ebreak},
          {28'd0, e.wen, e.ill, e.jmp, e.brk});
    end

    drive(SW_I, 32'h100, 32'hDEADBEEF);
    drive(LW_I, 32'h100, 0);   expect_now("lw_after_sw", 0, 32'hDEADBEEF);
    drive(LB_I, 32'h103, 0);   expect_now("lb_0x103", 0, 32'hFFFFFFDE);
    drive(LHU_I, 32'h102, 0);  expect_now("lhu_0x102", 0, 32'h0000DEAD);
    drive(LH_I, 32'h102, 0);   expect_now("lh_0x102", 0, 32'hFFFFDEAD);
    drive(LW_I, 32'h1100, 0);  expect_now("lw_wrap", 0, 32'hDEADBEEF);
    drive(SB_I, 32'h101, 32'h11);
    drive(LW_I, 32'h100, 0);   expect_now("lw_after_sb", 0, 32'hDEAD11EF);
    drive(SH_I, 32'h106, 32'hCAFE);
    drive(SW_I, 32'h104, 32'h0);
    drive(SH_I, 32'h106, 32'hCAFE);
    drive(LW_I, 32'h104, 0);   expect_now("lw_after_sh", 0, 32'hCAFE0000);
    expect_now("no_fault_aligned", 1, 0);

    drive(SW_I, 32'h102, 32'h55555555);
    drive(LW_I, 32'h100, 0);   expect_now("misaligned_sw_nowrite", 0, 32'hDEAD11EF);
    expect_now("fault_after_sw", 1, 1);
    drive(NOP_I, 0, 0); rst = 1'b0;
    drive(NOP_I, 0, 0); rst = 1'b1;
    expect_now("fault_cleared", 1, 0);

    drive(LH_I, 32'h101, 0);   expect_now("misaligned_lh_zero", 0, 0);
    drive(NOP_I, 0, 0);        expect_now("fault_after_lh", 1, 1);

    drive(SW_I, 32'h102, 32'h1); rst = 1'b0;
    drive(SW_I, 32'h100, 32'h0);
    expect_now("reset_beats_fault", 1, 0);
    drive(LW_I, 32'h100, 0); rst = 1'b1;
    expect_now("no_write_in_reset", 0, 32'hDEAD11EF);
    expect_now("fault_still_clear", 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_decode_exec_mem.md
Name: rv_decode_exec_mem

Overview:
- Combinational RV32I decode, ALU execute and data-memory access for the single-cycle core, plus a clocked data memory.
- The fetched instruction, PC and register-file read data come in.
- Register indices, immediate, ALU result, aligned load data and write-back controls go out.
- Sits between the instruction fetch/register file and the write-back mux.

Parameters:
- MEM_WORDS, 1024, data memory depth in 32-bit words (power of two).
- AW, 10, word-address width, equal to log2(MEM_WORDS).

Ports:
- clk  in  1  clock. One clock; all state updates on rising edge.
- rst  in  1  reset. Synchronous, active-low.
- inst  in  32  current instruction.
- pc  in  32  current PC.
- src1  in  32  register read data for rs1.
- src2  in  32  register read data for rs2.
- rs1  out  5  inst[19:15].
- rs2  out  5  inst[24:20].
- rd  out  5  inst[11:7].
- imm  out  32  sign-extended immediate.
- rf_wen  out  1  register write enable.
- func3  out  3  inst[14:12].
- opcode  out  7  inst[6:0].
- aluout  out  32  ALU result / effective address / jump target.
- load_data  out  32  extended load result.
- is_jump  out  1  JAL or JALR.
- ebreak  out  1  inst == 0x00100073.
- illegal  out  1  unsupported encoding.
- mem_fault  out  1  sticky misaligned-access flag.

Behaviour:
- Decode is combinational.
- Immediate by format:
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - All sign-extended from inst[31].
- Supported instructions and ALU selection (srcA, srcB, op):
  - LUI: (0, imm, ADD).
  - AUIPC: (pc, imm, ADD).
  - JAL: (pc, imm, ADD).
  - JALR: (src1, imm, ADD), then bit0 cleared.
  - Loads LB/LH/LW/LBU/LHU: (src1, imm, ADD).
  - Stores SB/SH/SW: (src1, imm, ADD).
  - OP-IMM ADDI/SLTI/SLTIU/XORI/ORI/ANDI: (src1, imm, op).
  - OP ADD/SUB/SLT/SLTU/XOR/OR/AND: (src1, src2, op); SUB when inst[30]=1.
  - EBREAK.
- ALU ops: ADD, SUB, AND, OR, XOR, SLT (signed, 1/0), SLTU (unsigned). 32-bit wrap-around arithmetic.
- rf_wen=1 for LUI, AUIPC, JAL, JALR, loads, OP-IMM, OP; otherwise 0.
  - rf_wen is forced 0 when illegal=1 or when rd=0.
- illegal=1 for any opcode/func3/func7 not listed above. This includes branches, shifts, fences and misc func3 values.
  - When illegal=1: rf_wen=0 and no store occurs.
- Memory addressing:
  - Word index = aluout[AW+1:2]; upper address bits are ignored (wrap modulo memory size).
  - Read is combinational from the word array.
- Loads: select byte/half by aluout[1:0] or aluout[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - Load of a misaligned halfword (addr[0]=1) or word (addr[1:0]!=0) returns 0.
- Stores write on the rising clk edge when rst=1 and the store is aligned.
  - SB: byte lane addr[1:0] receives src2[7:0].
  - SH: lanes addr[1]*2 .. +1 receive src2[15:0].
  - SW: full word receives src2.
  - Unselected byte lanes are unchanged.
- Misaligned store: no write. Store visibility: write in cycle N, readable combinationally in cycle N+1.
- mem_fault:
  - Set on the clock edge following any misaligned load or store.
  - Cleared only by reset; reset value 0.
  - Reset takes priority over a simultaneous fault.
- While rst=0: no memory write occurs. Memory contents are not reset; their power-up value is undefined.
- All combinational outputs track inputs regardless of reset.

Decomposition:
- Shared package rv_pkg holds:
  - opcode constants (LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, LOAD 0000011, STORE 0100011, OPIMM 0010011, OP 0110011, SYSTEM 1110011);
  - ALU op enum (3-bit: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6);
  - operand-select enums.
- One sub-module: rv_load_align (rdata word, addr[1:0], func3 -> load_data, misaligned).

Test Plan:
- ADDI x1,x0,-5 (0xFFB00093), src1=0 -> imm=0xFFFFFFFB, aluout=0xFFFFFFFB, rf_wen=1, rd=1, illegal=0.
- AUIPC x2,0x12345 at pc=0x80000000 -> aluout=0x92345000. JALR x1,4(x5) with src1=0x1003 -> aluout=0x1006, is_jump=1.
- SW src2=0xDEADBEEF to addr 0x100; next cycle LW 0x100 -> 0xDEADBEEF; LB 0x103 -> 0xFFFFFFDE; LHU 0x102 -> 0x0000DEAD.
- SB src2=0x11 at 0x101 over 0xDEADBEEF -> word reads 0xDEAD11EF.
- SW to 0x102 -> memory unchanged, mem_fault=1 next edge; hold rst=0 one cycle -> mem_fault=0.
- Store issued while rst=0 -> no write. 0x00100073 -> ebreak=1. SLLI (0x00109093) -> illegal=1, rf_wen=0.
